uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/uart_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_arb_pkg : shared types/constants for the UART word arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } arb_state_t;

  localparam int BYTE_W      = 8;
  localparam int BYTE_CYCLES = 12;

  // Counter width for a byte index that must be at least one bit wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rr_pick : combinational round-robin picker                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         winner,
  output logic                    valid
);

  localparam int IDX_W = $clog2(NREQ);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Search begins just after the last grant and wraps; last_grant itself is tried last.
  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDX_W'((int'(last_grant) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        winner[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin word scheduler for one UART serializer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int WORD_BYTES = 2
) (
  input  logic                           txclk,
  input  logic                           reset,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*WORD_BYTES*8-1:0]   req_data,
  output logic [NREQ-1:0]                grant,
  output logic [NREQ-1:0]                done,
  output logic                           busy,
  output logic                           ld_tx_data,
  output logic                           tx_enable,
  output logic [7:0]                     tx_data,
  input  logic                           tx_empty
);

  localparam int WORD_W = WORD_BYTES * BYTE_W;
  localparam int CNT_W  = cnt_width(WORD_BYTES);
  localparam int IDX_W  = $clog2(NREQ);

  arb_state_t        r_state, w_state_nxt;
  logic [WORD_W-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_byte_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_rr_ptr, w_ptr_nxt;
  logic [NREQ-1:0]   r_owner, w_owner_nxt;
  logic [NREQ-1:0]   r_grant, w_grant_nxt;
  logic [NREQ-1:0]   r_done, w_done_nxt;

  logic [WORD_W-1:0] w_words [NREQ];
  logic [NREQ-1:0]   w_winner;
  logic              w_valid;
  logic [IDX_W-1:0]  w_last;
  logic [IDX_W-1:0]  w_win_idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_words[i] = req_data[i*WORD_W +: WORD_W];
  end

  // r_rr_ptr holds the index searched first, so the picker sees the one before it.
  assign w_last = (r_rr_ptr == '0) ? IDX_W'(NREQ - 1) : r_rr_ptr - 1'b1;

  uart_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req        (req),
    .last_grant (w_last),
    .winner     (w_winner),
    .valid      (w_valid)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner[i]) w_win_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_done     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_cnt <= w_cnt_nxt;
      r_rr_ptr   <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_byte_cnt;
    w_ptr_nxt   = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_grant_nxt = '0;
    w_done_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (w_valid && tx_empty) begin
          w_shift_nxt = w_words[w_win_idx];
          w_cnt_nxt   = '0;
          w_grant_nxt = w_winner;
          w_owner_nxt = w_winner;
          w_ptr_nxt   = (w_win_idx == IDX_W'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: w_state_nxt = SEND;
      SEND: begin
        // tx_empty is low on the first SEND cycle because the serializer just loaded.
        if (tx_empty) begin
          if (r_byte_cnt == CNT_W'(WORD_BYTES - 1)) begin
            w_done_nxt  = r_owner;
            w_state_nxt = IDLE;
          end else begin
            w_shift_nxt = r_shift << BYTE_W;
            w_cnt_nxt   = r_byte_cnt + 1'b1;
            w_state_nxt = LOAD;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign busy       = (r_state != IDLE);
  assign ld_tx_data = (r_state == LOAD);
  assign tx_enable  = !(r_state == LOAD);
  assign tx_data    = r_shift[WORD_W-1 -: BYTE_W];

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter : scoreboard bench with serializer + line decoder  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NREQ = 3;
  localparam int WB   = 2;
  localparam int WW   = WB * 8;
  localparam int LAT  = 12 * WB;

  logic                 txclk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*WW-1:0]   req_data = '0;
  logic [NREQ-1:0]      grant, done;
  logic                 busy, ld_tx_data, tx_enable, tx_empty;
  logic [7:0]           tx_data;
  logic                 hold_empty = 1'b0;

  always #5 txclk = ~txclk;

  uart_tx_arbiter #(.NREQ(NREQ), .WORD_BYTES(WB)) dut (
    .txclk      (txclk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .ld_tx_data (ld_tx_data),
    .tx_enable  (tx_enable),
    .tx_data    (tx_data),
    .tx_empty   (tx_empty)
  );

  // 10-bit-period byte serializer: start, 8 data LSB first, stop.
  logic [9:0] ser_frame;
  logic [3:0] ser_cnt;
  logic       ser_empty, tx_out;

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      ser_frame <= '0;
      ser_cnt   <= '0;
    end else if (ld_tx_data) begin
      ser_frame <= {1'b1, tx_data, 1'b0};
      ser_cnt   <= 4'd10;
    end else if (tx_enable && ser_cnt != 0) begin
      ser_frame <= ser_frame >> 1;
      ser_cnt   <= ser_cnt - 1'b1;
    end
  end
  assign ser_empty = (ser_cnt == 0);
  assign tx_out    = (ser_cnt != 0) ? ser_frame[0] : 1'b1;
  assign tx_empty  = ser_empty & ~hold_empty;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: transaction-level timing and rotation priority.
  typedef struct { int who; int at; } done_t;
  logic [7:0]      byte_q[$];
  done_t           done_q[$];
  int              cyc     = 0;
  int              idle_at = 0;
  int              m_last  = NREQ - 1;
  logic [NREQ-1:0] exp_grant = '0;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge txclk) begin
    logic [NREQ-1:0] exp_d;
    int              w;
    done_t           d;
    cyc++;
    if (reset) begin
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ld", ld_tx_data, 0);
      chk("rst_txen", tx_enable, 1);
      chk("rst_txdata", tx_data, 0);
      byte_q.delete();
      done_q.delete();
      idle_at   = cyc;
      m_last    = NREQ - 1;
      exp_grant = '0;
    end else begin
      if (exp_grant != 0 || grant != 0) chk("grant", grant, exp_grant);
      chk("busy", busy, (cyc >= idle_at) ? 0 : 1);
      exp_d = '0;
      if (done_q.size() != 0 && done_q[0].at == cyc) begin
        d     = done_q.pop_front();
        exp_d = NREQ'(1) << d.who;
      end
      if (exp_d != 0 || done != 0) chk("done", done, exp_d);
      exp_grant = '0;
      if (cyc >= idle_at && req != 0 && tx_empty) begin
        w         = rr_pick(req, m_last);
        exp_grant = NREQ'(1) << w;
        m_last    = w;
        for (int b = WB - 1; b >= 0; b--) byte_q.push_back(req_data[w*WW + b*8 +: 8]);
        done_q.push_back('{who: w, at: cyc + 1 + LAT});
        idle_at = cyc + 1 + LAT;
      end
    end
  end

  // Line decoder pops the byte scoreboard once per complete frame.
  int         lm_bit = -1;
  logic [7:0] lm_byte = '0;

  always @(negedge txclk) begin
    if (reset) begin
      lm_bit = -1;
    end else if (lm_bit < 0) begin
      if (tx_out == 1'b0) lm_bit = 0;
    end else if (lm_bit < 8) begin
      lm_byte[lm_bit] = tx_out;
      lm_bit++;
    end else begin
      chk("stop_bit", tx_out, 1);
      if (byte_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL line_extra @%0t: got byte %0h expected none", $time, lm_byte);
      end else begin
        chk("line_byte", lm_byte, byte_q.pop_front());
      end
      lm_bit = -1;
    end
  end

  task automatic tick();
    @(posedge txclk);
    #1;
  endtask

  task automatic wait_grant(input int i);
    for (int n = 0; n < 200; n++) begin
      tick();
      if (grant[i]) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_grant timeout: got no grant expected grant[%0d]", i);
  endtask

  task automatic drain();
    repeat (LAT + 4) tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // single word
    req_data[0*WW +: WW] = 16'hA55A;
    req = 3'b001;
    wait_grant(0);
    req = '0;
    drain();

    // contention between requesters 0 and 1
    req_data[0*WW +: WW] = 16'h1234;
    req_data[1*WW +: WW] = 16'hBEEF;
    req = 3'b011;
    repeat (4 * (LAT + 1) + 2) tick();
    req = '0;
    drain();

    // fairness wrap after a grant to requester 2
    req_data[2*WW +: WW] = 16'hC3D2;
    req = 3'b100;
    wait_grant(2);
    req = 3'b101;
    repeat (2 * (LAT + 1) + 2) tick();
    req = '0;
    drain();

    // mid-word reset during second byte
    req_data[1*WW +: WW] = 16'h5AF0;
    req = 3'b010;
    wait_grant(1);
    req = '0;
    repeat (15) tick();
    reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_ld", ld_tx_data, 0);
    chk("async_txen", tx_enable, 1);
    tick();
    tick();
    reset = 1'b0;
    req_data[0*WW +: WW] = 16'h0F0F;
    req = 3'b011;
    wait_grant(0);
    req = 3'b010;
    wait_grant(1);
    req = '0;
    drain();

    // request dropped one cycle after grant
    req_data[1*WW +: WW] = 16'h7E81;
    req = 3'b010;
    wait_grant(1);
    tick();
    req = '0;
    drain();

    // serializer not ready in IDLE
    hold_empty = 1'b1;
    req_data[0*WW +: WW] = 16'h9966;
    req = 3'b001;
    repeat (5) tick();
    hold_empty = 1'b0;
    wait_grant(0);
    req = '0;
    drain();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && grant[i] && ($urandom % 2 == 0)) begin
          req[i] = 1'b0;
        end else if (!req[i] && ($urandom % 4 == 0)) begin
          req_data[i*WW +: WW] = WW'($urandom);
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    drain();
    drain();

    chk("bytes_left", byte_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
